serial_adder_ctrl: RTL and testbench

//  Bit-serial add controller. Shares one external 1-bit full-adder cell (a, b, cin -> sum, cout)

---
 rtl/serial_adder_ctrl.sv | 131 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add controller: streams operand bits LSB-first through one external
// full-adder cell, feeds the carry back and assembles the WIDTH-bit result.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic             load_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] res_sh_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;

  // Shift right inserting a new MSB; written this way so WIDTH=1 needs no special slice.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v, input logic bit_in);
    logic [WIDTH-1:0] r;
    r = v >> 1;
    r[WIDTH-1] = bit_in;
    return r;
  endfunction

  // Next-state decode and operand-load strobe
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s = ST_RUN;
          load_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == LAST_BIT) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Drive the shared full-adder cell only while bits are being processed
  always_comb begin
    fa_a   = 1'b0;
    fa_b   = 1'b0;
    fa_cin = 1'b0;
    if (state_r == ST_RUN) begin
      fa_a   = a_sh_r[0];
      fa_b   = b_sh_r[0];
      fa_cin = carry_r;
    end else begin
      fa_a   = 1'b0;
      fa_b   = 1'b0;
      fa_cin = 1'b0;
    end
  end

  // State register plus registered status flags decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_s;
      busy    <= (state_s == ST_RUN);
      done    <= (state_s == ST_DONE);
    end
  end

  // Operand shifters, carry feedback, bit counter and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r   <= '0;
      b_sh_r   <= '0;
      res_sh_r <= '0;
      carry_r  <= 1'b0;
      cnt_r    <= '0;
      sum      <= '0;
      cout     <= 1'b0;
    end else if (load_s) begin
      a_sh_r  <= a;
      b_sh_r  <= b;
      carry_r <= cin;
      cnt_r   <= '0;
    end else if (state_r == ST_RUN) begin
      a_sh_r   <= a_sh_r >> 1;
      b_sh_r   <= b_sh_r >> 1;
      res_sh_r <= shift_in(res_sh_r, fa_sum);
      carry_r  <= fa_cout;
      cnt_r    <= cnt_r + CW'(1);
      // sum/cout only move on the edge that consumes the final bit
      if (cnt_r == LAST_BIT) begin
        sum  <= shift_in(res_sh_r, fa_sum);
        cout <= fa_cout;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: WIDTH=8 cycle-by-cycle model check,
// exhaustive WIDTH=4 sweep and a WIDTH=1 smoke test.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // WIDTH=8 instance
  logic       start8, cin8, busy8, done8, cout8, fa_a8, fa_b8, fa_cin8, fa_sum8, fa_cout8;
  logic [7:0] a8, b8, sum8;
  // WIDTH=4 instance
  logic       start4, cin4, busy4, done4, cout4, fa_a4, fa_b4, fa_cin4, fa_sum4, fa_cout4;
  logic [3:0] a4, b4, sum4;
  // WIDTH=1 instance
  logic       start1, cin1, busy1, done1, cout1, fa_a1, fa_b1, fa_cin1, fa_sum1, fa_cout1;
  logic [0:0] a1, b1, sum1;

  // full-adder cells
  assign fa_sum8  = fa_a8 ^ fa_b8 ^ fa_cin8;
  assign fa_cout8 = (fa_a8 & fa_b8) | (fa_cin8 & (fa_a8 ^ fa_b8));
  assign fa_sum4  = fa_a4 ^ fa_b4 ^ fa_cin4;
  assign fa_cout4 = (fa_a4 & fa_b4) | (fa_cin4 & (fa_a4 ^ fa_b4));
  assign fa_sum1  = fa_a1 ^ fa_b1 ^ fa_cin1;
  assign fa_cout1 = (fa_a1 & fa_b1) | (fa_cin1 & (fa_a1 ^ fa_b1));

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
    .fa_a(fa_a8), .fa_b(fa_b8), .fa_cin(fa_cin8), .fa_sum(fa_sum8), .fa_cout(fa_cout8));

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4),
    .fa_a(fa_a4), .fa_b(fa_b4), .fa_cin(fa_cin4), .fa_sum(fa_sum4), .fa_cout(fa_cout4));

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
    .fa_a(fa_a1), .fa_b(fa_b1), .fa_cin(fa_cin1), .fa_sum(fa_sum1), .fa_cout(fa_cout1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model of the WIDTH=8 instance: remaining bit count and pending result
  int         m_rem = 0;
  bit         m_done = 1'b0;
  logic [7:0] m_sum = 8'h00;
  logic       m_cout = 1'b0;
  logic [8:0] m_pend = 9'h000;
  int         a_cap = 0, b_cap = 0, cin_cap = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem = 0; m_done = 1'b0; m_sum = 8'h00; m_cout = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          {m_cout, m_sum} = m_pend;
          m_done = 1'b1;
        end
      end else if (start8) begin
        a_cap = int'(a8); b_cap = int'(b8); cin_cap = int'(cin8);
        m_pend = 9'(a_cap + b_cap + cin_cap);
        m_rem = 8;
      end
    end
  end

  // Compare process: every cycle on the falling edge
  always @(negedge clk) begin
    int i, msk, e_a, e_b, e_c;
    i = 8 - m_rem;
    msk = (1 << i) - 1;
    e_a = 0; e_b = 0; e_c = 0;
    if (m_rem > 0) begin
      e_a = (a_cap >> i) & 1;
      e_b = (b_cap >> i) & 1;
      e_c = (((a_cap & msk) + (b_cap & msk) + cin_cap) >> i) & 1;
    end
    chk("busy", 32'(busy8), 32'(m_rem > 0));
    chk("done", 32'(done8), 32'(m_done));
    chk("sum", 32'(sum8), 32'(m_sum));
    chk("cout", 32'(cout8), 32'(m_cout));
    chk("fa_a", 32'(fa_a8), 32'(e_a));
    chk("fa_b", 32'(fa_b8), 32'(e_b));
    chk("fa_cin", 32'(fa_cin8), 32'(e_c));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done8(output int busy_cycles);
    busy_cycles = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done8) break;
      if (busy8) busy_cycles++;
    end
    if (!done8) chk("done8_timeout", 32'd0, 32'd1);
  endtask

  task automatic add8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    step();
    start8 = 1'b0;
  endtask

  initial begin
    int bc;
    int exp4;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_sum", 32'(sum8), 32'd0);
    chk("rst_cout", 32'(cout8), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // 1: plain add, 8 busy cycles, single-cycle done
    add8(8'h5A, 8'h3C, 1'b0);
    wait_done8(bc);
    chk("t1_busy_cycles", 32'(bc), 32'd8);
    chk("t1_sum", 32'(sum8), 32'h96);
    chk("t1_cout", 32'(cout8), 32'd0);
    @(negedge clk);
    chk("t1_done_pulse", 32'(done8), 32'd0);

    // 2: carry ripple to cout
    add8(8'hFF, 8'h01, 1'b0);
    wait_done8(bc);
    chk("t2a_sum", 32'(sum8), 32'h00);
    chk("t2a_cout", 32'(cout8), 32'd1);
    step();
    add8(8'hFF, 8'h00, 1'b1);
    wait_done8(bc);
    chk("t2b_sum", 32'(sum8), 32'h00);
    chk("t2b_cout", 32'(cout8), 32'd1);
    step();

    // 3: start held high, operands changed mid-run, then back-to-back from DONE
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
    step();
    a8 = 8'hFF;
    wait_done8(bc);
    chk("t3_sum", 32'(sum8), 32'h33);
    chk("t3_cout", 32'(cout8), 32'd0);
    @(negedge clk);
    chk("t3_b2b_busy", 32'(busy8), 32'd1);
    start8 = 1'b0;
    wait_done8(bc);
    chk("t3b_sum", 32'(sum8), 32'h21);
    chk("t3b_cout", 32'(cout8), 32'd1);
    step();

    // 4: reset after three bits aborts the add
    add8(8'h0F, 8'h01, 1'b0);
    repeat (3) step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t4_busy", 32'(busy8), 32'd0);
    chk("t4_sum", 32'(sum8), 32'd0);
    chk("t4_cout", 32'(cout8), 32'd0);
    step();
    rst_n = 1'b1;
    repeat (10) step();
    add8(8'h01, 8'h01, 1'b0);
    wait_done8(bc);
    chk("t4_sum2", 32'(sum8), 32'h02);
    step();

    // 5: back-to-back start issued in the DONE cycle; old sum holds until completion
    add8(8'h05, 8'h06, 1'b0);
    wait_done8(bc);
    chk("t5a_sum", 32'(sum8), 32'h0B);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    @(negedge clk);
    chk("t5_held_sum", 32'(sum8), 32'h0B);
    chk("t5_busy", 32'(busy8), 32'd1);
    wait_done8(bc);
    chk("t5_sum", 32'(sum8), 32'h00);
    chk("t5_cout", 32'(cout8), 32'd1);
    step();

    // 6: WIDTH=4 exhaustive
    for (int v = 0; v < 512; v++) begin
      a4 = 4'(v); b4 = 4'(v >> 4); cin4 = 1'(v >> 8);
      start4 = 1'b1;
      step();
      start4 = 1'b0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (done4) break;
      end
      exp4 = (v & 15) + ((v >> 4) & 15) + ((v >> 8) & 1);
      chk("w4_result", 32'({cout4, sum4}), 32'(exp4));
    end
    step();

    // WIDTH=1 smoke test
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done1) break;
    end
    chk("w1_done", 32'(done1), 32'd1);
    chk("w1_sum", 32'(sum1), 32'd1);
    chk("w1_cout", 32'(cout1), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 1000000");
    $fatal(1, "watchdog");
  end

endmodule
